// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the fetch PC, issues single-outstanding word reads to
// instruction memory and feeds a small first-word-fall-through queue toward the decoder.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_instr_pc,
  input  logic        i_instr_ready,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_misaligned
);

  localparam int unsigned PtrW = $clog2(BUF_DEPTH);
  localparam int unsigned CntW = $clog2(BUF_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(BUF_DEPTH);
  localparam logic [31:0] Nop = 32'h0000_0013;

  typedef enum logic [2:0] {
    StReqOff,
    StReq,
    StWait,
    StDrop,
    StHalt
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [31:0]     r_pc;
  logic [31:0]     r_out_pc;
  logic            r_halt_pend;
  logic            w_halt_pend_d;
  logic            r_misaligned;
  logic [31:0]     r_buf_instr [BUF_DEPTH];
  logic [31:0]     r_buf_pc    [BUF_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_nxt;

  logic w_misaligned_rd;
  logic w_aligned_rd;
  logic w_grant;
  logic w_valid;
  logic w_push;
  logic w_pop;
  logic w_outstanding;

  assign w_misaligned_rd = i_redirect & (i_redirect_pc[1:0] != 2'b00);
  assign w_aligned_rd    = i_redirect & (i_redirect_pc[1:0] == 2'b00);
  assign w_grant         = (r_state == StReq) & i_imem_gnt;
  assign w_valid         = (r_count != '0);
  // A redirect kills both the same-cycle push and the same-cycle pop.
  assign w_push          = (r_state == StWait) & i_imem_rvalid & ~i_redirect;
  assign w_pop           = w_valid & i_instr_ready & ~i_redirect;
  assign w_count_nxt     = r_count + CntW'(w_push) - CntW'(w_pop);

  // A response landing in the redirect cycle retires the request, so no drop state is needed.
  assign w_outstanding = w_grant |
                         (((r_state == StWait) | (r_state == StDrop)) & ~i_imem_rvalid);

  always_comb begin
    w_state_d     = r_state;
    w_halt_pend_d = r_halt_pend;
    unique case (r_state)
      StReqOff: if (r_count < DepthC) w_state_d = StReq;
      StReq:    if (i_imem_gnt) w_state_d = StWait;
      StWait: begin
        if (i_imem_rvalid) w_state_d = (w_count_nxt < DepthC) ? StReq : StReqOff;
      end
      StDrop:   if (i_imem_rvalid) w_state_d = r_halt_pend ? StHalt : StReq;
      StHalt:   w_state_d = StHalt;
      default:  w_state_d = StReqOff;
    endcase
    if (i_redirect) begin
      w_halt_pend_d = w_misaligned_rd;
      if (w_outstanding) begin
        w_state_d = StDrop;
      end else begin
        w_state_d = w_misaligned_rd ? StHalt : StReq;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StReqOff;
      r_pc         <= RESET_PC;
      r_out_pc     <= RESET_PC;
      r_halt_pend  <= 1'b0;
      r_misaligned <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_halt_pend  <= w_halt_pend_d;
      r_misaligned <= w_misaligned_rd;
      if (w_aligned_rd) begin
        r_pc <= i_redirect_pc;
      end else if (w_grant && !i_redirect) begin
        r_pc <= r_pc + 32'd4;
      end
      if (w_grant) r_out_pc <= r_pc;
      if (i_redirect) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
        r_count <= w_count_nxt;
      end
    end
  end

  // Queue payload needs no reset: it is only observed through the occupancy count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf_instr[r_wr_ptr] <= i_imem_rdata;
      r_buf_pc[r_wr_ptr]    <= r_out_pc;
    end
  end

  assign o_imem_req    = (r_state == StReq);
  assign o_imem_addr   = r_pc;
  assign o_instr_valid = w_valid;
  assign o_instruction = w_valid ? r_buf_instr[r_rd_ptr] : Nop;
  assign o_instr_pc    = w_valid ? r_buf_pc[r_rd_ptr] : 32'h0000_0000;
  assign o_misaligned  = r_misaligned;

endmodule
